bridge_rr_axil: RTL and testbench
=================================

# bridge_rr_axil

Parametrised successor to the single-client DRAM bridge. It accepts one-word read/write requests from NCH independent client channels and arbitrates them round-robin onto one AXI4-Lite master port toward the pseudo DRAM. Each completed request is returned to its own channel as a one-cycle response pulse. It sits between the OS-class controllers and the DRAM model in the lab testbed, and lets several controllers share the DRAM.

## Interface
Parameters:
- NCH, 2: number of client channels (1..8).
- ADDR_W, 17: DRAM byte-address width.
- DATA_W, 64: data word width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- C_in_valid  in  NCH  per-channel request pulse; one cycle wide.
- C_r_wb  in  NCH  per-channel direction: 1 = read, 0 = write.
- C_addr  in  NCH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- C_data_w  in  NCH*DATA_W  per-channel write data.
- C_out_valid  out  NCH  per-channel completion pulse.
- C_data_r  out  NCH*DATA_W  per-channel read data; valid only while the matching C_out_valid is high.
- C_err  out  NCH  per-channel error flag; valid only with C_out_valid; set when the response is nonzero.
- AR_VALID/AR_ADDR/AR_READY, R_VALID/R_DATA/R_RESP/R_READY  AXI-Lite read channels; master side; widths 1/ADDR_W/1, 1/DATA_W/2/1.
- AW_VALID/AW_ADDR/AW_READY, W_VALID/W_DATA/W_READY, B_VALID/B_RESP/B_READY  AXI-Lite write channels; master side; widths 1/ADDR_W/1, 1/DATA_W/1, 1/2/1.

## Operation
- Each channel has one pending slot holding {r_wb, addr, data}.
  - The slot is loaded on C_in_valid.
  - It clears when the channel's completion pulse is issued.
  - A C_in_valid on a channel whose slot is already pending is ignored; the original request is kept.
- Arbiter:
  - In IDLE, it grants the first pending channel at or after rr_ptr, searching cyclically upward.
  - After a grant, rr_ptr becomes granted+1 mod NCH.
  - A request arriving in the same cycle as an IDLE evaluation is not visible until the next cycle, because its slot is registered.
- FSM states: IDLE, AR, R, AW, W, B, RSP.
  - IDLE -> AR when the granted channel is a read; IDLE -> AW when it is a write.
  - AR: AR_VALID=1 and AR_ADDR=slot.addr; -> R on AR_READY.
  - R: R_READY=1; on R_VALID, capture R_DATA and (R_RESP!=0); -> RSP.
  - AW: AW_VALID=1; -> W on AW_READY.
  - W: W_VALID=1 and W_DATA=slot.data; -> B on W_READY.
  - B: B_READY=1; on B_VALID, capture (B_RESP!=0); -> RSP.
  - RSP: pulse C_out_valid[g] for one cycle and clear slot g; -> IDLE.
- C_data_r lanes:
  - On a read, the granted lane carries the captured data during RSP.
  - On a write, the granted lane is 0.
  - Lanes of all other channels are 0 at all times.
- All AXI *_VALID and *_READY outputs are registered. Their address and data buses are held stable while VALID is high and are 0 otherwise.

## Timing
- Reset (async assert, sync to clk edge on release): state=IDLE; all slots empty; rr_ptr=0; every output 0.
- Reset asserted mid-transaction:
  - All outputs drop immediately.
  - The in-flight request is lost, with no completion pulse.
  - Late AXI responses arriving after release are ignored, since the FSM is in IDLE and all READYs are 0.
- Read latency, zero-wait DRAM, C_in_valid at cycle t:
  - Slot loaded at t+1, grant evaluated at t+1.
  - AR_VALID at t+2, R at t+3, C_out_valid at t+4.
  - Each DRAM wait cycle adds one cycle.
- Write latency, zero-wait DRAM: C_out_valid at t+6 (AW t+2, W t+3, B t+4, capture, RSP t+6).
- Only one AXI transaction is outstanding at a time. AR and AW are never asserted together.
- Back-to-back: IDLE is occupied for one cycle between consecutive grants.
- Fairness: with all NCH channels continuously pending, each channel is served once every NCH transactions.

## Test plan
- Reset mid-read: assert rst while in state R -> all outputs 0 within the same cycle; no C_out_valid; a subsequent R_VALID is ignored.
- Single read, NCH=2, DRAM[0x10000]=64'h0123_4567_89AB_CDEF, zero-wait: ch0 read pulse at t -> AR_ADDR=0x10000 at t+2; C_out_valid=2'b01 with C_data_r lane0=64'h0123_4567_89AB_CDEF at t+4; C_err=0.
- Write then read back, ch1: write 64'hDEAD_BEEF_0000_0001 to 0x10008, then read 0x10008 -> write completion pulse carries lane1=0; read returns 64'hDEAD_BEEF_0000_0001.
- Simultaneous requests, NCH=4, all channels pulse in the same cycle, rr_ptr=0 -> completions in order ch0, ch1, ch2, ch3. A new ch0 request pulsed during ch1's service is served after ch3.
- Duplicate pulse: ch0 reads 0x10000, and ch0 pulses a write to 0x10010 while the first request is pending -> exactly one completion, a read of 0x10000; DRAM[0x10010] is unchanged.
- Backpressure and error: DRAM holds AR_READY=0 for 5 cycles and returns R_RESP=2'b10 -> AR_VALID/AR_ADDR stay stable for 6 cycles; C_err=1 with C_out_valid; C_out_valid arrives 5 cycles later than the zero-wait case.

Source files
------------

// File: rtl/bridge_rr_axil_if.sv
// bridge_rr_axil_if: AXI4-Lite master/slave bundle used by the round-robin DRAM bridge
interface bridge_rr_axil_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
);
  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;
  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
endinterface

// File: rtl/bridge_rr_axil.sv
// bridge_rr_axil: NCH one-word client channels arbitrated round-robin onto one AXI4-Lite master
module bridge_rr_axil #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        C_in_valid,
  input  logic [NCH-1:0]        C_r_wb,
  input  logic [NCH*ADDR_W-1:0] C_addr,
  input  logic [NCH*DATA_W-1:0] C_data_w,
  output logic [NCH-1:0]        C_out_valid,
  output logic [NCH*DATA_W-1:0] C_data_r,
  output logic [NCH-1:0]        C_err,
  bridge_rr_axil_if.master      m
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RSP} state_t;
  state_t state, state_n;
  logic [NCH-1:0] pend, rwb, ld, clr;
  logic [ADDR_W-1:0] addr [NCH];
  logic [DATA_W-1:0] wdat [NCH];
  logic [PW-1:0] rr, rr_n, g, g_n, sel;
  logic found, err;
  logic [DATA_W-1:0] rdata;
  assign ld  = C_in_valid & ~pend;
  assign clr = (state == RSP) ? NCH'(1) << g : '0;
  // a pulse on an already-pending channel is dropped so the original request survives
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      rwb  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (ld[i]) begin
          pend[i] <= 1'b1;
          rwb[i]  <= C_r_wb[i];
        end else if (clr[i]) pend[i] <= 1'b0;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      if (ld[i]) begin
        addr[i] <= C_addr[i*ADDR_W +: ADDR_W];
        wdat[i] <= C_data_w[i*DATA_W +: DATA_W];
      end
  // scan downward so the smallest cyclic offset from rr wins
  always_comb begin
    logic [PW:0] s;
    s     = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      s = {1'b0, rr} + (PW+1)'(k);
      s = (s >= (PW+1)'(NCH)) ? s - (PW+1)'(NCH) : s;
      if (pend[s[PW-1:0]]) begin
        found = 1'b1;
        sel   = s[PW-1:0];
      end
    end
  end
  always_comb begin
    state_n = state;
    g_n     = g;
    rr_n    = rr;
    unique case (state)
      IDLE: if (found) begin
        g_n     = sel;
        rr_n    = (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;
        state_n = rwb[sel] ? AR : AW;
      end
      AR:  state_n = m.AR_READY ? R : AR;
      R:   state_n = m.R_VALID ? RSP : R;
      AW:  state_n = m.AW_READY ? W : AW;
      W:   state_n = m.W_READY ? B : W;
      B:   state_n = m.B_VALID ? RSP : B;
      RSP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // AXI outputs are registered from the next state so they change only on clock edges
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      g          <= '0;
      rr         <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      m.AR_VALID <= 1'b0;
      m.AR_ADDR  <= '0;
      m.R_READY  <= 1'b0;
      m.AW_VALID <= 1'b0;
      m.AW_ADDR  <= '0;
      m.W_VALID  <= 1'b0;
      m.W_DATA   <= '0;
      m.B_READY  <= 1'b0;
    end else begin
      state <= state_n;
      g     <= g_n;
      rr    <= rr_n;
      if (state == R && m.R_VALID) begin
        rdata <= m.R_DATA;
        err   <= |m.R_RESP;
      end else if (state == B && m.B_VALID) begin
        rdata <= '0;
        err   <= |m.B_RESP;
      end
      m.AR_VALID <= state_n == AR;
      m.AR_ADDR  <= (state_n == AR) ? addr[g_n] : '0;
      m.R_READY  <= state_n == R;
      m.AW_VALID <= state_n == AW;
      m.AW_ADDR  <= (state_n == AW) ? addr[g_n] : '0;
      m.W_VALID  <= state_n == W;
      m.W_DATA   <= (state_n == W) ? wdat[g_n] : '0;
      m.B_READY  <= state_n == B;
    end
  assign C_out_valid = clr;
  assign C_err       = err ? clr : '0;
  always_comb begin
    C_data_r = '0;
    for (int i = 0; i < NCH; i++)
      C_data_r[i*DATA_W +: DATA_W] = clr[i] ? rdata : '0;
  end
endmodule

// File: tb/tb_bridge_rr_axil.sv
// tb_bridge_rr_axil: directed checks of the round-robin AXI-Lite bridge against a small DRAM model
module tb_bridge_rr_axil;
  localparam int NCH = 4, AW = 17, DW = 64;
  localparam logic [63:0] M0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M2 = 64'h5555_AAAA_0000_0010;
  localparam logic [63:0] WD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D2 = 64'h0F0F_1234_5678_0018;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [NCH-1:0] in_valid, r_wb, out_valid, err;
  logic [NCH*AW-1:0] addr_bus;
  logic [NCH*DW-1:0] wdata_bus, rdata_bus;
  bridge_rr_axil_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  bridge_rr_axil #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .C_in_valid(in_valid), .C_r_wb(r_wb), .C_addr(addr_bus),
    .C_data_w(wdata_bus), .C_out_valid(out_valid), .C_data_r(rdata_bus), .C_err(err), .m(bus)
  );
  // DRAM model: word index is addr[5:3]; a write commits one cycle before B is answered
  logic [63:0] mem [8] = '{0: M0, 2: M2, default: 64'h0};
  int stall_cfg, ar_wait;
  logic [1:0] resp_cfg, rresp;
  logic r_mask, r_force, rv, bp, bv;
  logic [63:0] rd;
  logic [2:0] wa;
  assign bus.AR_READY = bus.AR_VALID && ar_wait >= stall_cfg;
  assign bus.R_VALID  = (rv && !r_mask) || r_force;
  assign bus.R_DATA   = rd;
  assign bus.R_RESP   = rresp;
  assign bus.AW_READY = bus.AW_VALID;
  assign bus.W_READY  = bus.W_VALID;
  assign bus.B_VALID  = bv;
  assign bus.B_RESP   = 2'b00;
  always @(posedge clk or posedge rst)
    if (rst) begin
      rv <= 0; bp <= 0; bv <= 0; rd <= '0; rresp <= '0; wa <= '0; ar_wait <= 0;
    end else begin
      ar_wait <= (bus.AR_VALID && !bus.AR_READY) ? ar_wait + 1 : 0;
      if (bus.AR_VALID && bus.AR_READY) begin
        rv <= 1; rd <= mem[bus.AR_ADDR[5:3]]; rresp <= resp_cfg;
      end else if (bus.R_VALID && bus.R_READY) rv <= 0;
      if (bus.AW_VALID && bus.AW_READY) wa <= bus.AW_ADDR[5:3];
      if (bus.W_VALID && bus.W_READY) mem[wa] <= bus.W_DATA;
      bp <= bus.W_VALID && bus.W_READY;
      if (bp) bv <= 1; else if (bv && bus.B_READY) bv <= 0;
    end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [NCH-1:0] v; logic [NCH*DW-1:0] d; logic [NCH-1:0] e; int c; } cpl_t;
  cpl_t q[$];
  int ar_len = 0, last_ar_len = 0, ar_unstable = 0, both = 0, aw_seen = 0;
  logic [AW-1:0] ar_prev = '0;
  always @(negedge clk) begin
    if (|out_valid) q.push_back('{out_valid, rdata_bus, err, cyc});
    ar_len <= bus.AR_VALID ? ar_len + 1 : 0;
    if (!bus.AR_VALID && ar_len != 0) last_ar_len <= ar_len;
    if (bus.AR_VALID && ar_len != 0 && bus.AR_ADDR != ar_prev) ar_unstable <= ar_unstable + 1;
    ar_prev <= bus.AR_ADDR;
    if (bus.AR_VALID && bus.AW_VALID) both <= both + 1;
    if (bus.AW_VALID) aw_seen <= aw_seen + 1;
  end
  int checks = 0, failures = 0;
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put(int ch, logic rdw, logic [AW-1:0] a, logic [DW-1:0] d);
    in_valid[ch] = 1'b1;
    r_wb[ch] = rdw;
    addr_bus[ch*AW +: AW] = a;
    wdata_bus[ch*DW +: DW] = d;
  endtask
  task automatic step();
    @(negedge clk); #1;
    in_valid = '0;
  endtask
  task automatic wait_q(int n, int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("completion_count", 256'(q.size()), 256'(n));
    @(negedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    cpl_t e;
    int t, aw0, k;
    logic seen;
    in_valid = '0; r_wb = '0; addr_bus = '0; wdata_bus = '0;
    stall_cfg = 0; resp_cfg = 2'b00; r_mask = 0; r_force = 0;
    repeat (3) @(negedge clk); #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_axi_ctl", 256'({bus.AR_VALID, bus.AW_VALID, bus.W_VALID, bus.R_READY, bus.B_READY}), 256'(0));
    chk("rst_buses", 256'({bus.AR_ADDR, bus.AW_ADDR, bus.W_DATA}), 256'(0));
    chk("rst_data_r", 256'(rdata_bus), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    // single zero-wait read
    put(0, 1'b1, 17'h10000, 64'h0);
    t = cyc;
    step();
    @(negedge clk); #1;
    chk("rd_ar_valid_t2", 256'(bus.AR_VALID), 256'(1));
    chk("rd_ar_addr_t2", 256'(bus.AR_ADDR), 256'(17'h10000));
    wait_q(1, 20);
    e = q.pop_front();
    chk("rd_vec", 256'(e.v), 256'(4'b0001));
    chk("rd_lat", 256'(e.c), 256'(t + 4));
    chk("rd_data", 256'(e.d), 256'(M0));
    chk("rd_err", 256'(e.e), 256'(0));
    // write then read back on ch1
    put(1, 1'b0, 17'h10008, WD);
    t = cyc;
    step();
    wait_q(1, 20);
    e = q.pop_front();
    chk("wr_vec", 256'(e.v), 256'(4'b0010));
    chk("wr_lat", 256'(e.c), 256'(t + 6));
    chk("wr_data_zero", 256'(e.d), 256'(0));
    chk("wr_err", 256'(e.e), 256'(0));
    put(1, 1'b1, 17'h10008, 64'h0);
    step();
    wait_q(1, 20);
    e = q.pop_front();
    chk("rb_vec", 256'(e.v), 256'(4'b0010));
    chk("rb_data", 256'(e.d), 256'(WD) << 64);
    // all channels at once from rr_ptr=0, plus a late ch0 request
    do_reset();
    @(negedge clk); #1;
    put(0, 1'b1, 17'h10000, 64'h0);
    put(1, 1'b1, 17'h10008, 64'h0);
    put(2, 1'b0, 17'h10018, D2);
    put(3, 1'b1, 17'h10010, 64'h0);
    t = cyc;
    step();
    wait_q(1, 20);
    put(0, 1'b1, 17'h10018, 64'h0);
    step();
    wait_q(5, 80);
    e = q.pop_front();
    chk("rr0_vec", 256'(e.v), 256'(4'b0001));
    chk("rr0_data", 256'(e.d), 256'(M0));
    chk("rr0_lat", 256'(e.c), 256'(t + 4));
    e = q.pop_front();
    chk("rr1_vec", 256'(e.v), 256'(4'b0010));
    chk("rr1_data", 256'(e.d), 256'(WD) << 64);
    chk("rr1_lat", 256'(e.c), 256'(t + 8));
    e = q.pop_front();
    chk("rr2_vec", 256'(e.v), 256'(4'b0100));
    chk("rr2_data", 256'(e.d), 256'(0));
    chk("rr2_lat", 256'(e.c), 256'(t + 14));
    e = q.pop_front();
    chk("rr3_vec", 256'(e.v), 256'(4'b1000));
    chk("rr3_data", 256'(e.d), 256'(M2) << 192);
    chk("rr3_lat", 256'(e.c), 256'(t + 18));
    e = q.pop_front();
    chk("rr4_vec", 256'(e.v), 256'(4'b0001));
    chk("rr4_data", 256'(e.d), 256'(D2));
    chk("rr4_lat", 256'(e.c), 256'(t + 22));
    // duplicate pulse while pending is dropped
    aw0 = aw_seen;
    put(0, 1'b1, 17'h10000, 64'h0);
    step();
    put(0, 1'b0, 17'h10010, 64'hBAD0_BAD0_BAD0_BAD0);
    step();
    wait_q(1, 20);
    e = q.pop_front();
    chk("dup_vec", 256'(e.v), 256'(4'b0001));
    chk("dup_data", 256'(e.d), 256'(M0));
    repeat (15) @(negedge clk);
    #1;
    chk("dup_no_extra", 256'(q.size()), 256'(0));
    chk("dup_no_aw", 256'(aw_seen), 256'(aw0));
    chk("dup_mem", 256'(mem[2]), 256'(M2));
    // AR backpressure with error response
    stall_cfg = 5;
    resp_cfg = 2'b10;
    put(0, 1'b1, 17'h10000, 64'h0);
    t = cyc;
    step();
    wait_q(1, 40);
    e = q.pop_front();
    chk("bp_vec", 256'(e.v), 256'(4'b0001));
    chk("bp_lat", 256'(e.c), 256'(t + 9));
    chk("bp_err", 256'(e.e), 256'(4'b0001));
    chk("bp_data", 256'(e.d), 256'(M0));
    chk("bp_ar_len", 256'(last_ar_len), 256'(6));
    chk("bp_ar_stable", 256'(ar_unstable), 256'(0));
    stall_cfg = 0;
    resp_cfg = 2'b00;
    // reset while waiting in R, then a stray R_VALID
    r_mask = 1;
    put(1, 1'b1, 17'h10008, 64'h0);
    step();
    k = 0;
    while (!bus.R_READY && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("mid_reached_r", 256'(bus.R_READY), 256'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_out_valid", 256'(out_valid), 256'(0));
    chk("mid_axi_ctl", 256'({bus.AR_VALID, bus.AW_VALID, bus.W_VALID, bus.R_READY, bus.B_READY}), 256'(0));
    chk("mid_data_r", 256'(rdata_bus), 256'(0));
    @(negedge clk); #1;
    rst = 1'b0;
    r_mask = 0;
    r_force = 1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      seen = seen | bus.R_READY | (|out_valid);
    end
    r_force = 0;
    chk("mid_ignored", 256'(seen), 256'(0));
    chk("mid_no_cpl", 256'(q.size()), 256'(0));
    put(2, 1'b1, 17'h10000, 64'h0);
    step();
    wait_q(1, 20);
    e = q.pop_front();
    chk("rec_vec", 256'(e.v), 256'(4'b0100));
    chk("rec_data", 256'(e.d), 256'(M0) << 128);
    chk("no_ar_aw_overlap", 256'(both), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
